// File: rtl/adder_measure_sequencer_if.sv
// Bundle of control, operand and result signals shared by the measurement
// sequencer and whoever drives it (controller side = master).
interface adder_measure_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             abort;
  logic [31:0]      a_req;
  logic [31:0]      b_req;
  logic [15:0]      window_cycles;
  logic [31:0]      s_output;
  logic             chain_out;
  logic [31:0]      a_input;
  logic [31:0]      b_input;
  logic             ring_en;
  logic             busy;
  logic             done;
  logic [31:0]      sum_result;
  logic [CNT_W-1:0] edge_count;

  modport slave (
    input  start, abort, a_req, b_req, window_cycles, s_output, chain_out,
    output a_input, b_input, ring_en, busy, done, sum_result, edge_count
  );

  modport master (
    output start, abort, a_req, b_req, window_cycles, s_output, chain_out,
    input  a_input, b_input, ring_en, busy, done, sum_result, edge_count
  );
endinterface

// File: rtl/adder_measure_sequencer.sv
// Sequences one adder measurement: load operands, settle, count ring edges
// over a window, capture the sum, pulse done. Abort returns to IDLE at once.
module adder_measure_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 32
) (
  input logic                      wb_clk_i,
  input logic                      wb_rst_n,
  adder_measure_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SETTLE  = 3'd2,
    MEASURE = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [31:0]      a_input_q;
  logic [31:0]      b_input_q;
  logic [15:0]      window_q;
  logic [7:0]       settle_cnt_q;
  logic [15:0]      meas_cnt_q;
  logic             ring_en_q;
  logic             busy_q;
  logic             done_q;
  logic [31:0]      sum_result_q;
  logic [CNT_W-1:0] edge_count_q;
  logic [CNT_W-1:0] edge_count_d;
  logic             sync1_q;
  logic             sync2_q;
  logic             sync3_q;
  logic             rise_q;

  // chain_out is asynchronous: two-flop synchronizer, then a registered rise detector
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= bus.chain_out;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      rise_q  <= sync2_q & ~sync3_q;
    end
  end

  // Saturating increment; only used while measuring
  always_comb begin
    edge_count_d = edge_count_q;
    if (rise_q && (edge_count_q != CNT_MAX)) begin
      edge_count_d = edge_count_q + CNT_ONE;
    end else begin
      edge_count_d = edge_count_q;
    end
  end

  // Sequencer FSM with all outputs registered alongside the state
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q      <= IDLE;
      a_input_q    <= 32'd0;
      b_input_q    <= 32'd0;
      window_q     <= 16'd0;
      settle_cnt_q <= 8'd0;
      meas_cnt_q   <= 16'd0;
      ring_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sum_result_q <= 32'd0;
      edge_count_q <= '0;
    end else if (bus.abort && (state_q != IDLE)) begin
      // Abort wins over everything; results keep whatever they held
      state_q   <= IDLE;
      ring_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= LOAD;
            a_input_q <= bus.a_req;
            b_input_q <= bus.b_req;
            window_q  <= bus.window_cycles;
            busy_q    <= 1'b1;
          end
        end
        LOAD: begin
          state_q      <= SETTLE;
          settle_cnt_q <= 8'd0;
          meas_cnt_q   <= 16'd0;
          edge_count_q <= '0;
        end
        SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            meas_cnt_q <= 16'd0;
            if (window_q == 16'd0) begin
              state_q <= CAPTURE;
            end else begin
              state_q   <= MEASURE;
              ring_en_q <= 1'b1;
            end
          end else begin
            settle_cnt_q <= settle_cnt_q + 8'd1;
          end
        end
        MEASURE: begin
          edge_count_q <= edge_count_d;
          if (meas_cnt_q == (window_q - 16'd1)) begin
            state_q   <= CAPTURE;
            ring_en_q <= 1'b0;
          end else begin
            meas_cnt_q <= meas_cnt_q + 16'd1;
          end
        end
        CAPTURE: begin
          sum_result_q <= bus.s_output;
          state_q      <= DONE;
          done_q       <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          ring_en_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a_input    = a_input_q;
  assign bus.b_input    = b_input_q;
  assign bus.ring_en    = ring_en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.sum_result = sum_result_q;
  assign bus.edge_count = edge_count_q;

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// Directed bench: stimulus pushes expected results, a negedge monitor pops
// and compares on every done pulse. A second instance exercises saturation.
module tb_adder_measure_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [3:0] ph = 4'd0;
  logic chain_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) ph <= ph + 4'd1;

  adder_measure_sequencer_if #(.CNT_W(32)) bus ();
  adder_measure_sequencer_if #(.CNT_W(4))  bus_s ();

  assign bus.s_output    = bus.a_input + bus.b_input;
  assign bus.chain_out   = chain_en & ph[1];
  assign bus_s.s_output  = bus_s.a_input + bus_s.b_input;
  assign bus_s.chain_out = ph[0];

  adder_measure_sequencer #(.SETTLE_CYCLES(4), .CNT_W(32)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .bus(bus)
  );
  adder_measure_sequencer #(.SETTLE_CYCLES(4), .CNT_W(4)) dut_s (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .bus(bus_s)
  );

  typedef struct {
    logic [31:0] sum;
    int          lo;
    int          hi;
    int          lat;
    int          ring;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   ring_cnt = 0;

  task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1'b0, 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("sum_result", bus.sum_result === mon_e.sum, bus.sum_result, mon_e.sum);
        chk("edge_count", (int'(bus.edge_count) >= mon_e.lo) && (int'(bus.edge_count) <= mon_e.hi),
            bus.edge_count, mon_e.lo);
        chk("latency", (cyc - mon_e.start_cyc) == mon_e.lat, cyc - mon_e.start_cyc, mon_e.lat);
        chk("ring_cycles", ring_cnt == mon_e.ring, ring_cnt, mon_e.ring);
      end
    end
    if (bus.busy !== 1'b1) ring_cnt = 0;
    else if (bus.ring_en === 1'b1) ring_cnt = ring_cnt + 1;
  end

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", bus.done === 1'b1, n, budget);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [15:0] w,
                     input int lo, input int hi, input bit with_abort);
    exp_t e;
    e.sum = a + b;
    e.lo = lo;
    e.hi = hi;
    e.lat = 2 + 4 + int'(w);
    e.ring = int'(w);
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    bus.a_req = a;
    bus.b_req = b;
    bus.window_cycles = w;
    bus.abort = with_abort;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    wait_done(e.lat + 10);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1;
    exp_t e2;
    int   n;
    int   dones;
    bus.start = 1'b0;  bus.abort = 1'b0;  bus.a_req = 32'd0;  bus.b_req = 32'd0;
    bus.window_cycles = 16'd0;
    bus_s.start = 1'b0;  bus_s.abort = 1'b0;  bus_s.a_req = 32'd0;  bus_s.b_req = 32'd0;
    bus_s.window_cycles = 16'd0;
    repeat (3) @(negedge clk);

    chk("rst_busy", bus.busy === 1'b0, bus.busy, 0);
    chk("rst_done", bus.done === 1'b0, bus.done, 0);
    chk("rst_ring_en", bus.ring_en === 1'b0, bus.ring_en, 0);
    chk("rst_sum", bus.sum_result === 32'd0, bus.sum_result, 0);
    chk("rst_edge", bus.edge_count === 32'd0, bus.edge_count, 0);
    chk("rst_a_input", bus.a_input === 32'd0, bus.a_input, 0);

    // Basic run, started on the very first edge after reset release
    rst_n = 1'b1;
    run(32'h0000_0003, 32'h0000_0005, 16'd10, 0, 0, 1'b0);

    // Edge counting, period-4 chain over a 40-cycle window
    chain_en = 1'b1;
    run(32'h1234_5678, 32'h1111_1111, 16'd40, 9, 11, 1'b0);

    // Zero window: chain still toggling but nothing may be counted
    run(32'hFFFF_FFFF, 32'h0000_0002, 16'd0, 0, 0, 1'b0);
    chain_en = 1'b0;

    // Start held through DONE: back-to-back runs, operands change only at a start edge
    e1.sum = 32'd2;  e1.lo = 0;  e1.hi = 0;  e1.lat = 8;  e1.ring = 2;  e1.start_cyc = cyc + 1;
    e2.sum = 32'd30; e2.lo = 0;  e2.hi = 0;  e2.lat = 8;  e2.ring = 2;  e2.start_cyc = cyc + 11;
    sb.push_back(e1);
    sb.push_back(e2);
    bus.a_req = 32'd1;  bus.b_req = 32'd1;  bus.window_cycles = 16'd2;  bus.start = 1'b1;
    @(negedge clk);
    bus.a_req = 32'd10;  bus.b_req = 32'd20;
    wait_done(20);
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    chk("held_start_a_input", bus.a_input === 32'd10, bus.a_input, 10);
    @(negedge clk);
    wait_done(20);
    @(negedge clk);

    // Abort in the 3rd MEASURE cycle
    bus.a_req = 32'd100;  bus.b_req = 32'd200;  bus.window_cycles = 16'd20;  bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.ring_en !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_measure", bus.ring_en === 1'b1, n, 50);
    repeat (2) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy === 1'b0, bus.busy, 0);
    chk("abort_ring_en", bus.ring_en === 1'b0, bus.ring_en, 0);
    chk("abort_sum_kept", bus.sum_result === 32'd30, bus.sum_result, 30);
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("abort_no_done", dones == 0, dones, 0);

    // Saturation on the 4-bit counter instance
    bus_s.a_req = 32'd7;  bus_s.b_req = 32'd8;  bus_s.window_cycles = 16'd64;  bus_s.start = 1'b1;
    @(negedge clk);
    bus_s.start = 1'b0;
    n = 0;
    while (bus_s.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("sat_done", bus_s.done === 1'b1, n, 100);
    chk("sat_edge_count", bus_s.edge_count === 4'hF, bus_s.edge_count, 15);
    chk("sat_sum", bus_s.sum_result === 32'd15, bus_s.sum_result, 15);
    @(negedge clk);

    // Reset between edges during SETTLE
    bus.a_req = 32'd9;  bus.b_req = 32'd9;  bus.window_cycles = 16'd10;  bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy === 1'b0, bus.busy, 0);
    chk("mid_rst_ring_en", bus.ring_en === 1'b0, bus.ring_en, 0);
    chk("mid_rst_done", bus.done === 1'b0, bus.done, 0);
    chk("mid_rst_a_input", bus.a_input === 32'd0, bus.a_input, 0);
    chk("mid_rst_b_input", bus.b_input === 32'd0, bus.b_input, 0);
    chk("mid_rst_sum", bus.sum_result === 32'd0, bus.sum_result, 0);
    chk("mid_rst_edge", bus.edge_count === 32'd0, bus.edge_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Normal run after release, with abort asserted in IDLE alongside start
    run(32'h0F0F_0F0F, 32'hF0F0_F0F0, 16'd3, 0, 0, 1'b1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size() == 0, sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
